// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared types and default widths for the two-master memory arbiter.  Rev 1.0
`default_nettype none

package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_M0 = 1'b0,
      OWN_M1 = 1'b1
   } arb_owner_t;

   localparam int ADDR_W_DEFAULT = 8;
   localparam int DATA_W_DEFAULT = 8;
   localparam int STARVE_CNT_W   = 4;

endpackage

`default_nettype wire

// File: rtl/mem_arb_select.sv
// mem_arb_select -- winner pick for the arbiter; fixed priority with m1 starvation guard,
// or round-robin when MEM_ARB_ROUND_ROBIN_EN is defined.  Rev 1.0
`default_nettype none

module mem_arb_select
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
`ifdef MEM_ARB_ROUND_ROBIN_EN
   input  arb_owner_t last_owner,
`else
   input  logic       clock,
   input  logic       reset,
   input  logic       arb_en,
`endif
   input  logic       m0_req,
   input  logic       m1_req,
   output logic       any_req,
   output arb_owner_t winner
);

   assign any_req = m0_req | m1_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN

   // On contention the master that was not granted last wins.
   always_comb begin
      winner = OWN_M0;
      if (m1_req && (!m0_req || last_owner == OWN_M0)) begin
         winner = OWN_M1;
      end
   end

`else

   localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

   logic [STARVE_CNT_W-1:0] starve_cnt;

   always_comb begin
      winner = OWN_M0;
      if (m1_req && (!m0_req || starve_cnt == LIMIT)) begin
         winner = OWN_M1;
      end
   end

   // Counts contentions m1 has lost since its last grant.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (arb_en && any_req) begin
         if (winner == OWN_M1) begin
            starve_cnt <= '0;
         end else if (m1_req && starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
      end
   end

`endif

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter -- shares one synchronous memory port between CPU (m0) and DMA/loader (m1).
// Optional round-robin mode: MEM_ARB_ROUND_ROBIN_EN.  Rev 1.0
`default_nettype none

module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEFAULT,
   parameter int DATA_W       = DATA_W_DEFAULT,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              m0_req,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out,
   output logic              busy
);

   arb_state_t        state;
   arb_state_t        state_next;
   arb_owner_t        owner;
   arb_owner_t        winner;
   logic              any_req;
   logic              arbitrate;
   logic [DATA_W-1:0] m0_rdata_q;
   logic [DATA_W-1:0] m1_rdata_q;

   assign arbitrate = (state == IDLE) || (state == RESP);

   mem_arb_select #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_select (
`ifdef MEM_ARB_ROUND_ROBIN_EN
      .last_owner (owner),
`else
      .clock      (clock),
      .reset      (reset),
      .arb_en     (arbitrate),
`endif
      .m0_req     (m0_req),
      .m1_req     (m1_req),
      .any_req    (any_req),
      .winner     (winner)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, RESP: state_next = any_req ? ACCESS : IDLE;
         ACCESS:     state_next = mem_write ? IDLE : RESP;
         default:    state_next = IDLE;
      endcase
   end

   // mem_write is only ever high during ACCESS; every other edge clears it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         owner       <= OWN_M0;
         mem_address <= '0;
         mem_write   <= 1'b0;
         mem_data_in <= '0;
      end else if (arbitrate && any_req) begin
         owner <= winner;
         if (winner == OWN_M1) begin
            mem_address <= m1_addr;
            mem_write   <= m1_write;
            mem_data_in <= m1_wdata;
         end else begin
            mem_address <= m0_addr;
            mem_write   <= m0_write;
            mem_data_in <= m0_wdata;
         end
      end else begin
         mem_write <= 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
      end else if (state == RESP) begin
         if (owner == OWN_M1) begin
            m1_rdata_q <= mem_data_out;
         end else begin
            m0_rdata_q <= mem_data_out;
         end
      end
   end

   assign m0_gnt    = (state == ACCESS) && (owner == OWN_M0);
   assign m1_gnt    = (state == ACCESS) && (owner == OWN_M1);
   assign m0_rvalid = (state == RESP) && (owner == OWN_M0);
   assign m1_rvalid = (state == RESP) && (owner == OWN_M1);
   // Memory data is presented straight through during RESP, then held from the register.
   assign m0_rdata  = m0_rvalid ? mem_data_out : m0_rdata_q;
   assign m1_rdata  = m1_rvalid ? mem_data_out : m1_rdata_q;
   assign busy      = (state != IDLE);

endmodule

`default_nettype wire
